// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame controller and bit encoder.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam int PIXEL_BITS_DFLT = 24;
  localparam int CNT_GAP_DFLT    = 16000;
  localparam int CNT_W           = 16;

  // Encoder bit timing in clk_in cycles at 200 MHz.
  localparam int CNT_0_35_US = 70;
  localparam int CNT_0_70_US = 140;
  localparam int CNT_1_25_US = 250;

endpackage

// File: rtl/ws2812_pix_buf.sv
// One-deep pixel prefetch buffer with remaining-fetch counter and registered request.
module ws2812_pix_buf
  import ws2812_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DFLT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load,
  input  logic [CNT_W-1:0]      load_cnt,
  input  logic                  take,
  input  logic                  pixel_vld_in,
  input  logic [PIXEL_BITS-1:0] pixel_data_in,
  output logic                  pixel_req_out,
  output logic                  buf_vld,
  output logic [PIXEL_BITS-1:0] buf_data
);

  logic [CNT_W-1:0] fetch_left;
  logic [CNT_W-1:0] fetch_left_nxt;
  logic             buf_vld_nxt;
  logic             xfer;

  assign xfer = pixel_req_out & pixel_vld_in;

  // An incoming word always lands in the buffer, even when the old one is taken the same cycle.
  always_comb begin
    buf_vld_nxt    = buf_vld;
    fetch_left_nxt = fetch_left;
    if (take) buf_vld_nxt = 1'b0;
    if (xfer) begin
      buf_vld_nxt    = 1'b1;
      fetch_left_nxt = fetch_left - CNT_W'(1);
    end
    if (load) begin
      buf_vld_nxt    = 1'b0;
      fetch_left_nxt = load_cnt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_vld       <= 1'b0;
      buf_data      <= '0;
      fetch_left    <= '0;
      pixel_req_out <= 1'b0;
    end else begin
      buf_vld       <= buf_vld_nxt;
      fetch_left    <= fetch_left_nxt;
      pixel_req_out <= !buf_vld_nxt && (fetch_left_nxt != '0);
      if (xfer) buf_data <= pixel_data_in;
    end
  end

endmodule

// File: rtl/ws2812_frame_ctl.sv
// WS2812 frame sequencer: fetches pixels, serialises them MSB-first to the encoder, then latch gap.
// Build option WS2812_FRAME_CTL_LOOP_EN: repeat the frame continuously after the first start.
//
// state | meaning
// IDLE  | waiting for frame_start_in with a non-zero pixel count
// LOAD  | waiting for a buffered pixel to copy into the shift register
// SEND  | bit_rdy_out pulse, bit_data_out holds the current MSB
// WAIT  | waiting for bit_done_in from the encoder
// GAP   | line held low for the latch gap
module ws2812_frame_ctl
  import ws2812_pkg::*;
#(
  parameter int PIXEL_BITS = PIXEL_BITS_DFLT,
  parameter int CNT_GAP    = CNT_GAP_DFLT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic [CNT_W-1:0]      pixel_num_in,
  output logic                  pixel_req_out,
  input  logic                  pixel_vld_in,
  input  logic [PIXEL_BITS-1:0] pixel_data_in,
  output logic                  bit_rdy_out,
  output logic                  bit_data_out,
  input  logic                  bit_done_in,
  output logic                  frame_busy_out,
  output logic                  frame_done_out,
  output logic                  underrun_out
);

  localparam int IDX_W = $clog2(PIXEL_BITS);

  state_t                state;
  logic [PIXEL_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic [CNT_W-1:0]      pix_num;
  logic [CNT_W-1:0]      pix_left;
  logic [CNT_W-1:0]      gap_cnt;
  logic                  first_pix;

  logic                  buf_vld;
  logic [PIXEL_BITS-1:0] buf_data;
  logic                  buf_load;
  logic                  buf_take;
  logic [CNT_W-1:0]      buf_load_cnt;
  logic                  start_ok;
  logic                  gap_end;

  assign start_ok     = (state == ST_IDLE) && frame_start_in && (pixel_num_in != '0);
  assign gap_end      = (state == ST_GAP) && (gap_cnt == '0);
  assign buf_take     = (state == ST_LOAD) && buf_vld;
  assign buf_load_cnt = (state == ST_IDLE) ? pixel_num_in : pix_num;
`ifdef WS2812_FRAME_CTL_LOOP_EN
  assign buf_load = start_ok || gap_end;
`else
  assign buf_load = start_ok;
`endif

  ws2812_pix_buf #(
    .PIXEL_BITS(PIXEL_BITS)
  ) u_pix_buf (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load         (buf_load),
    .load_cnt     (buf_load_cnt),
    .take         (buf_take),
    .pixel_vld_in (pixel_vld_in),
    .pixel_data_in(pixel_data_in),
    .pixel_req_out(pixel_req_out),
    .buf_vld      (buf_vld),
    .buf_data     (buf_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ST_IDLE;
      shift_reg      <= '0;
      bit_idx        <= '0;
      pix_num        <= '0;
      pix_left       <= '0;
      gap_cnt        <= '0;
      first_pix      <= 1'b0;
      bit_rdy_out    <= 1'b0;
      bit_data_out   <= 1'b0;
      frame_busy_out <= 1'b0;
      frame_done_out <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      bit_rdy_out    <= 1'b0;
      frame_done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            pix_num        <= pixel_num_in;
            pix_left       <= pixel_num_in;
            first_pix      <= 1'b1;
            underrun_out   <= 1'b0;
            frame_busy_out <= 1'b1;
            state          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (buf_vld) begin
            shift_reg    <= buf_data;
            bit_idx      <= IDX_W'(PIXEL_BITS - 1);
            first_pix    <= 1'b0;
            bit_rdy_out  <= 1'b1;
            bit_data_out <= buf_data[PIXEL_BITS-1];
            state        <= ST_SEND;
          end else if (!first_pix) begin
            underrun_out <= 1'b1;
          end
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bit_done_in) begin
            shift_reg <= shift_reg << 1;
            if (bit_idx != '0) begin
              bit_idx      <= bit_idx - IDX_W'(1);
              bit_rdy_out  <= 1'b1;
              bit_data_out <= shift_reg[PIXEL_BITS-2];
              state        <= ST_SEND;
            end else begin
              bit_data_out <= 1'b0;
              pix_left     <= pix_left - CNT_W'(1);
              if (pix_left != CNT_W'(1)) begin
                state <= ST_LOAD;
              end else begin
                gap_cnt <= CNT_W'(CNT_GAP - 1);
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            frame_done_out <= 1'b1;
`ifdef WS2812_FRAME_CTL_LOOP_EN
            pix_left       <= pix_num;
            first_pix      <= 1'b1;
            state          <= ST_LOAD;
`else
            frame_busy_out <= 1'b0;
            state          <= ST_IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ws2812_frame_ctl.md
Name: ws2812_frame_ctl

Overview:
Frame-level sequencer for the single-bit WS2812 encoder.
- Fetches 24-bit GRB pixels from an upstream source through a one-deep prefetch buffer.
- Serialises each pixel MSB-first into the encoder's bit_rdy/bit_data/bit_done handshake.
- After the last bit, holds the line idle for a latch (reset) gap, then signals frame completion.
- Sits between the pixel memory/stream front-end and the bit encoder; one instance per LED chain.

Parameters:
PIXEL_BITS, 24, bits per pixel, shifted MSB first.
CNT_GAP, 16000, latch-gap length in clk_in cycles (80 us at 200 MHz); counter is 16 bits wide.

Ports:
clk_in  input  1  clock.
rst_in  input  1  synchronous reset, active-high.
frame_start_in  input  1  one-cycle pulse that starts a frame; honoured only in IDLE.
pixel_num_in  input  16  pixel count, latched on an accepted frame_start_in.
pixel_req_out  output  1  level; high while the prefetch buffer is empty and pixels remain to be fetched.
pixel_vld_in  input  1  pixel_data_in is valid; a transfer happens on a cycle with pixel_req_out & pixel_vld_in.
pixel_data_in  input  PIXEL_BITS  pixel word, G[23:16] R[15:8] B[7:0].
bit_rdy_out  output  1  one-cycle pulse that launches one encoder bit.
bit_data_out  output  1  bit value; stable from the bit_rdy_out cycle until the cycle after bit_done_in.
bit_done_in  input  1  one-cycle pulse from the encoder at the end of a bit.
frame_busy_out  output  1  high in every state other than IDLE.
frame_done_out  output  1  one-cycle pulse when the latch gap expires.
underrun_out  output  1  sticky flag; set when the buffer is empty at a pixel boundary; cleared by an accepted frame_start_in.

Behaviour:
- Reset (synchronous, rst_in=1): state IDLE. All outputs 0. Buffer invalid. Counters 0. Reset mid-frame aborts immediately; bit_rdy_out is never pulsed in the reset cycle.
- All outputs are registered.
- States: IDLE, LOAD, SEND, WAIT, GAP.
- IDLE:
  - On frame_start_in with pixel_num_in != 0: latch the pixel count, set fetch_left = pixel_num_in, clear underrun_out, go to LOAD.
  - frame_start_in with pixel_num_in == 0 is ignored; no frame_done_out.
- frame_start_in is ignored in any state other than IDLE.
- Prefetch buffer:
  - pixel_req_out = !buf_vld & (fetch_left != 0).
  - On a transfer: buf_vld <= 1, fetch_left decrements.
  - Fetching overlaps shifting, so the next pixel can arrive while the current one is still being sent.
- LOAD:
  - If buf_vld: copy the buffer to the shift register, clear buf_vld, set bit index = PIXEL_BITS-1, go to SEND.
  - If !buf_vld and this is not the first pixel: set underrun_out and wait. The line stays low.
  - A transfer and a LOAD copy in the same cycle: the copy wins and the incoming pixel is registered into the buffer. No loss.
- SEND: bit_rdy_out=1 for exactly one cycle; bit_data_out = shift register MSB; go to WAIT.
- WAIT:
  - On bit_done_in, shift left by 1.
  - If bits remain in the pixel: go to SEND, so bit_rdy_out rises the cycle after bit_done_in.
  - If the pixel is finished and more pixels remain: go to LOAD.
  - If the pixel is finished and it was the last pixel: go to GAP.
- With a prefetched pixel, LOAD costs 1 cycle per pixel boundary; bit spacing is otherwise constant.
- GAP: count 0..CNT_GAP-1 with bit_data_out=0. On the terminal count, pulse frame_done_out and go to IDLE.
- bit_done_in is ignored outside WAIT.

Optional Feature:
Macro WS2812_FRAME_CTL_LOOP_EN.
- Defined: at the end of GAP, the block pulses frame_done_out and re-enters LOAD with the latched pixel count reloaded into fetch_left. It runs continuously until reset. frame_start_in then only starts the first frame.
- Undefined: the block returns to IDLE after each frame.

Decomposition:
- Package ws2812_pkg: state enum, PIXEL_BITS, CNT_GAP default, and the encoder timing constants CNT_0_35_US / CNT_0_70_US / CNT_1_25_US shared with the encoder.
- One sub-module: ws2812_pix_buf (one-deep prefetch buffer, fetch_left counter, pixel_req_out generation).

Test Plan:
- Reset -> all outputs 0; rst_in asserted mid-WAIT -> state IDLE next cycle, no further bit_rdy_out pulses.
- 1-pixel frame, pixel 0xA5_00_FF, encoder attached at 200 MHz -> bit_data_out sequence 10100101 00000000 11111111, 24 bit_rdy_out pulses spaced 253 cycles apart, frame_done_out exactly CNT_GAP cycles after the cycle following the last bit_done_in.
- 3-pixel frame, pixel_vld_in always 1 -> exactly 3 transfers, 72 bit_rdy_out pulses, 1 extra cycle at each pixel boundary, underrun_out stays 0.
- 2-pixel frame, pixel 2 delayed 1000 cycles after pixel 1 completes -> underrun_out=1 and the line stays low during the wait, then pixel 2 bits are sent correctly.
- frame_start_in in WAIT/GAP ignored; pixel_num_in=0 ignored (frame_busy_out stays 0, no frame_done_out).
- WS2812_FRAME_CTL_LOOP_EN defined, 1-pixel frame -> frame_done_out repeats every 24 bits + gap with pixel_req_out re-asserted each loop.
